fifo_param: RTL
===============

# fifo_param

Parametrised synchronous FIFO for the transmission-layer data path. It generalises the per-lane FIFOs in width, depth and threshold programmability. It adds overflow/underflow protection, a registered read with a valid qualifier, a fill-level output and a sticky, clearable error flag. It sits between the byte/lane steering logic and the lane serialisers and is instantiated once per lane.

## Interface
- DATA_WIDTH, 6, width of each stored word
- ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH entries
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- wr_enable  input  1  push request
- rd_enable  input  1  pop request
- data_in  input  DATA_WIDTH  write data
- umbral_alto  input  ADDR_WIDTH+1  almost-full threshold (level)
- umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold (level)
- err_clear  input  1  synchronous clear of sticky error
- data_out  output  DATA_WIDTH  registered read data
- valid_out  output  1  data_out holds a popped word this cycle
- fill_level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  output  1 each  status flags
- error  output  1  sticky overflow/underflow indicator

## Operation
- Accept rules (per cycle):
  - rd_accept = rd_enable && !empty.
  - wr_accept = wr_enable && (!full || rd_accept).
- Write: on wr_accept, mem[wr_ptr] <= data_in and wr_ptr increments modulo DEPTH.
- Read: on rd_accept, data_out <= mem[rd_ptr], valid_out <= 1, and rd_ptr increments modulo DEPTH. With no accepted read, data_out <= 0 and valid_out <= 0.
- fill_level update: +1 on write only, -1 on read only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Flags are combinational from fill_level:
  - full = (fill_level == DEPTH); empty = (fill_level == 0).
  - almost_full = (fill_level >= umbral_alto); almost_empty = (fill_level <= umbral_bajo).
  - Thresholds are compared live, with no latching.
- Overflow: wr_enable while full without rd_accept. The write is dropped, memory and pointers are unchanged, and error is set.
- Underflow: rd_enable while empty. The read is rejected, valid_out = 0, data_out = 0, and error is set.
- Simultaneous wr+rd:
  - At full, both are accepted, the level stays DEPTH and there is no error.
  - At empty, the write is accepted and the read is rejected (no bypass). fill_level becomes 1 and error is set (underflow).
- error is sticky and holds until reset or err_clear. If err_clear coincides with a new violation, set wins (error stays 1).
- Memory contents are not reset. Stale entries are never observable because reads are gated by empty.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - wr_ptr, rd_ptr and fill_level go to 0; data_out = 0; valid_out = 0; error = 0.
  - Flags: empty = 1, full = 0, almost_full = (umbral_alto == 0), almost_empty = 1.
- Reset mid-operation: all state clears immediately, independent of clk. Any in-flight words are discarded.
- Write-to-flag latency: 1 cycle. fill_level and flags update on the edge that accepts the push.
- Read latency: 1 cycle. The word appears on data_out with valid_out = 1 on the edge after rd_enable is sampled, and is held for exactly that one cycle.
- Back-to-back reads: one word per cycle with valid_out continuously high, in FIFO order.
- Pointer wrap: DEPTH-1 to 0 with no bubble.
- Error: set on the edge that samples the violation; cleared on the edge that samples err_clear.

## Test plan
Unless stated, DATA_WIDTH = 6, ADDR_WIDTH = 2 (DEPTH = 4), umbral_alto = 3, umbral_bajo = 1.
- **Reset:** hold reset for 3 cycles with random inputs -> data_out = 0, valid_out = 0, fill_level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, error = 0.
- **Fill and drain:** write 0x11, 0x22, 0x33, 0x04 on consecutive cycles -> fill_level 1, 2, 3, 4; almost_full rises at level 3 and full at level 4. Then 4 consecutive reads -> data_out = 0x11, 0x22, 0x33, 0x04 with valid_out high one cycle after each rd_enable; empty = 1 at the end.
- **Overflow:** at full, write 0x3F with no read -> error = 1, fill_level stays 4, drain returns 0x11..0x04 unchanged. Pulse err_clear -> error = 0 next cycle.
- **Underflow:** at empty, rd_enable = 1 -> valid_out = 0, data_out = 0, error = 1. With wr+rd at empty (data 0x2A) -> fill_level = 1, error = 1, a subsequent read returns 0x2A.
- **Simultaneous at full with wrap:** after pointer wrap, assert wr+rd for 6 cycles with data 0x01..0x06 -> fill_level stays 4, no error, outputs follow FIFO order across the wrap. Then change umbral_alto to 4 -> almost_full follows combinationally.
- **Asynchronous reset mid-burst:** assert reset between clock edges at level 2 -> all outputs reach reset values before the next edge. After release, the first read on empty flags underflow and returns no stale data.

Source files
------------

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised per-lane FIFO with registered read, fill level and sticky error
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  overflow;
  logic                  underflow;

  // Status flags are pure functions of the level; thresholds are compared live
  assign full         = (fill_level == DEPTH_LVL);
  assign empty        = (fill_level == '0);
  assign almost_full  = (fill_level >= umbral_alto);
  assign almost_empty = (fill_level <= umbral_bajo);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
  // A read on empty is never bypassed from the incoming write.
  assign rd_accept = rd_enable && !empty;
  assign wr_accept = wr_enable && (!full || rd_accept);
  assign overflow  = wr_enable && full && !rd_accept;
  assign underflow = rd_enable && empty;

  // Storage array: no reset, stale entries are unreachable because reads are gated by empty
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally at DEPTH because they are exactly ADDR_WIDTH bits wide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: accept rules keep it within 0..DEPTH, simultaneous push/pop cancels out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_level <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   fill_level <= fill_level + LVL_ONE;
        2'b01:   fill_level <= fill_level - LVL_ONE;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Registered read port: data is zeroed whenever no word was popped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (rd_accept) begin
      data_out  <= mem[rd_ptr];
      valid_out <= 1'b1;
    end else begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end
  end

  // Sticky error: a new violation takes priority over a coincident clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (overflow || underflow) begin
      error <= 1'b1;
    end else if (err_clear) begin
      error <= 1'b0;
    end
  end

endmodule
